// File: rtl/control_unit_staged.sv
// Registered ID-stage control decode with load-use bubble insertion and a RUN/DRAIN/HALTED halt FSM.
// Optional macro CU_LINK_EN adds JAL / JALR link decoding; without it o_link is constant 0.
module control_unit_staged #(
    parameter int NB           = 32,
    parameter int NB_REGS      = 5,
    parameter int NB_OPCODE    = 6,
    parameter int NB_SIZE_TYPE = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NB-1:0]           i_instruction,
    input  logic                    i_enable,
    input  logic                    i_flush,
    output logic                    o_stall,
    output logic                    o_ALUSrc,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic                    o_mem_to_reg,
    output logic                    o_reg_write,
    output logic [NB_REGS-1:0]      o_reg_dir_to_write,
    output logic                    o_branch,
    output logic                    o_jump,
    output logic                    o_link,
    output logic                    o_halt,
    output logic                    o_signed,
    output logic [1:0]              o_ExtensionMode,
    output logic [NB_SIZE_TYPE-1:0] o_word_size,
    output logic                    o_halted
);

    localparam int CNT_W  = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int OP_LSB = NB - NB_OPCODE;
    localparam int RS_LSB = OP_LSB - NB_REGS;
    localparam int RT_LSB = RS_LSB - NB_REGS;
    localparam int RD_LSB = RT_LSB - NB_REGS;

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [NB_OPCODE-1:0] OP_RTYPE = 6'h00;
    localparam logic [NB_OPCODE-1:0] OP_J     = 6'h02;
    localparam logic [NB_OPCODE-1:0] OP_JAL   = 6'h03;
    localparam logic [NB_OPCODE-1:0] OP_BEQ   = 6'h04;
    localparam logic [NB_OPCODE-1:0] OP_BNE   = 6'h05;
    localparam logic [NB_OPCODE-1:0] OP_ADDI  = 6'h08;
    localparam logic [NB_OPCODE-1:0] OP_SLTI  = 6'h0A;
    localparam logic [NB_OPCODE-1:0] OP_ANDI  = 6'h0C;
    localparam logic [NB_OPCODE-1:0] OP_ORI   = 6'h0D;
    localparam logic [NB_OPCODE-1:0] OP_XORI  = 6'h0E;
    localparam logic [NB_OPCODE-1:0] OP_LUI   = 6'h0F;
    localparam logic [NB_OPCODE-1:0] OP_LB    = 6'h20;
    localparam logic [NB_OPCODE-1:0] OP_LH    = 6'h21;
    localparam logic [NB_OPCODE-1:0] OP_LW    = 6'h23;
    localparam logic [NB_OPCODE-1:0] OP_LBU   = 6'h24;
    localparam logic [NB_OPCODE-1:0] OP_LHU   = 6'h25;
    localparam logic [NB_OPCODE-1:0] OP_LWU   = 6'h27;
    localparam logic [NB_OPCODE-1:0] OP_SB    = 6'h28;
    localparam logic [NB_OPCODE-1:0] OP_SH    = 6'h29;
    localparam logic [NB_OPCODE-1:0] OP_SW    = 6'h2B;
    localparam logic [NB_OPCODE-1:0] FN_JALR  = 6'h09;

    localparam logic [NB-1:0] HALT_INSTR = {NB{1'b1}};

    localparam logic [1:0] EXT_SIGNED   = 2'b00;
    localparam logic [1:0] EXT_UNSIGNED = 2'b01;

    localparam logic [NB_SIZE_TYPE-1:0] BYTE_WORD     = 3'b001;
    localparam logic [NB_SIZE_TYPE-1:0] HALF_WORD     = 3'b010;
    localparam logic [NB_SIZE_TYPE-1:0] COMPLETE_WORD = 3'b100;

    typedef struct packed {
        logic                    alu_src;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    reg_write;
        logic [NB_REGS-1:0]      dest;
        logic                    branch;
        logic                    jump;
`ifdef CU_LINK_EN
        logic                    link;
`endif
        logic                    halt;
        logic                    sign;
        logic [1:0]              ext_mode;
        logic [NB_SIZE_TYPE-1:0] word_size;
    } ctrl_t;

    // The bubble doubles as the reset word: no side effects, rt operand, signed, full word.
    function automatic ctrl_t bubble_word();
        ctrl_t w;
        w           = '0;
        w.alu_src   = 1'b0;
        w.ext_mode  = EXT_SIGNED;
        w.word_size = COMPLETE_WORD;
        return w;
    endfunction

    function automatic ctrl_t load_word(input logic [NB_REGS-1:0] rt,
                                        input logic [NB_SIZE_TYPE-1:0] size,
                                        input logic sgn);
        ctrl_t w;
        w            = bubble_word();
        w.alu_src    = 1'b1;
        w.mem_read   = 1'b1;
        w.mem_to_reg = 1'b1;
        w.reg_write  = 1'b1;
        w.dest       = rt;
        w.sign       = sgn;
        w.word_size  = size;
        return w;
    endfunction

    function automatic ctrl_t store_word(input logic [NB_SIZE_TYPE-1:0] size);
        ctrl_t w;
        w           = bubble_word();
        w.alu_src   = 1'b1;
        w.mem_write = 1'b1;
        w.word_size = size;
        return w;
    endfunction

    function automatic ctrl_t imm_word(input logic [NB_REGS-1:0] rt, input logic [1:0] ext);
        ctrl_t w;
        w           = bubble_word();
        w.alu_src   = 1'b1;
        w.reg_write = 1'b1;
        w.dest      = rt;
        w.ext_mode  = ext;
        return w;
    endfunction

    function automatic ctrl_t decode_word(input logic [NB-1:0] instr);
        ctrl_t                w;
        logic [NB_OPCODE-1:0] op;
        logic [NB_REGS-1:0]   rt;
        logic [NB_REGS-1:0]   rd;
        op = instr[OP_LSB +: NB_OPCODE];
        rt = instr[RT_LSB +: NB_REGS];
        rd = instr[RD_LSB +: NB_REGS];
        w  = bubble_word();
        if (instr == HALT_INSTR) begin
            w.halt = 1'b1;
        end else begin
            case (op)
                OP_RTYPE: begin
                    w.reg_write = 1'b1;
                    w.dest      = rd;
`ifdef CU_LINK_EN
                    // JALR only records the link; the target is resolved downstream.
                    w.link      = (instr[NB_OPCODE-1:0] == FN_JALR);
`endif
                end
                OP_ADDI, OP_SLTI:                 w = imm_word(rt, EXT_SIGNED);
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w = imm_word(rt, EXT_UNSIGNED);
                OP_BEQ, OP_BNE:                   w.branch = 1'b1;
                OP_J:                             w.jump   = 1'b1;
`ifdef CU_LINK_EN
                OP_JAL: begin
                    w.jump      = 1'b1;
                    w.reg_write = 1'b1;
                    w.link      = 1'b1;
                    w.dest      = {NB_REGS{1'b1}};
                end
`endif
                OP_LB:   w = load_word(rt, BYTE_WORD, 1'b1);
                OP_LH:   w = load_word(rt, HALF_WORD, 1'b1);
                OP_LW:   w = load_word(rt, COMPLETE_WORD, 1'b1);
                OP_LBU:  w = load_word(rt, BYTE_WORD, 1'b0);
                OP_LHU:  w = load_word(rt, HALF_WORD, 1'b0);
                OP_LWU:  w = load_word(rt, COMPLETE_WORD, 1'b0);
                OP_SB:   w = store_word(BYTE_WORD);
                OP_SH:   w = store_word(HALF_WORD);
                OP_SW:   w = store_word(COMPLETE_WORD);
                default: w = bubble_word();
            endcase
        end
        return w;
    endfunction

    function automatic logic reads_rt(input logic [NB_OPCODE-1:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: reads_rt = 1'b1;
            default:                                       reads_rt = 1'b0;
        endcase
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    ctrl_t              ctrl_r;
    ctrl_t              ctrl_nxt_s;
    ctrl_t              decoded_s;
    logic [NB_REGS-1:0] rs_s;
    logic [NB_REGS-1:0] rt_s;
    logic               load_use_s;
    logic               hazard_s;

    assign decoded_s = decode_word(i_instruction);
    assign rs_s      = i_instruction[RS_LSB +: NB_REGS];
    assign rt_s      = i_instruction[RT_LSB +: NB_REGS];

    // The load being registered now lands in EX next cycle; its result is not forwardable yet.
    assign load_use_s = ctrl_r.mem_read && (ctrl_r.dest != {NB_REGS{1'b0}}) &&
                        ((ctrl_r.dest == rs_s) ||
                         ((ctrl_r.dest == rt_s) && reads_rt(i_instruction[OP_LSB +: NB_OPCODE])));
    assign hazard_s   = load_use_s && (state_r == ST_RUN) && !i_flush;
    assign o_stall    = hazard_s || (state_r != ST_RUN);

    // Next state, drain counter and next control word in per-edge priority order.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ctrl_nxt_s  = ctrl_r;
        if (!i_enable) begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            ctrl_nxt_s  = ctrl_r;
        end else if (i_flush) begin
            // A halt caught in a taken-branch shadow is cancelled; HALTED is only left via reset.
            ctrl_nxt_s = bubble_word();
            cnt_nxt_s  = CNT_ZERO;
            if (state_r == ST_HALTED) begin
                state_nxt_s = ST_HALTED;
            end else begin
                state_nxt_s = ST_RUN;
            end
        end else if (state_r != ST_RUN) begin
            ctrl_nxt_s = bubble_word();
            case (state_r)
                ST_DRAIN: begin
                    if (cnt_r <= CNT_ONE) begin
                        state_nxt_s = ST_HALTED;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end
                ST_HALTED: begin
                    state_nxt_s = ST_HALTED;
                    cnt_nxt_s   = CNT_ZERO;
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end else if (hazard_s) begin
            ctrl_nxt_s = bubble_word();
            cnt_nxt_s  = CNT_ZERO;
        end else begin
            ctrl_nxt_s = decoded_s;
            if (decoded_s.halt) begin
                state_nxt_s = ST_DRAIN;
                cnt_nxt_s   = DRAIN_LOAD;
            end else begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = CNT_ZERO;
            end
        end
    end

    // State, counter and ID/EX control word registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
            ctrl_r  <= bubble_word();
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
        end
    end

    assign o_ALUSrc           = ctrl_r.alu_src;
    assign o_mem_read         = ctrl_r.mem_read;
    assign o_mem_write        = ctrl_r.mem_write;
    assign o_mem_to_reg       = ctrl_r.mem_to_reg;
    assign o_reg_write        = ctrl_r.reg_write;
    assign o_reg_dir_to_write = ctrl_r.dest;
    assign o_branch           = ctrl_r.branch;
    assign o_jump             = ctrl_r.jump;
    assign o_halt             = ctrl_r.halt;
    assign o_signed           = ctrl_r.sign;
    assign o_ExtensionMode    = ctrl_r.ext_mode;
    assign o_word_size        = ctrl_r.word_size;
    assign o_halted           = (state_r == ST_HALTED);
`ifdef CU_LINK_EN
    assign o_link             = ctrl_r.link;
`else
    assign o_link             = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit_staged.sv
// Self-checking bench for control_unit_staged: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the decode/hazard/halt rules.
module tb_control_unit_staged;

    localparam int DRAIN = 3;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] instr  = 32'h0;
    logic        enable = 1'b0;
    logic        flush  = 1'b0;

    logic       o_stall, o_ALUSrc, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
    logic [4:0] o_reg_dir_to_write;
    logic       o_branch, o_jump, o_link, o_halt, o_signed, o_halted;
    logic [1:0] o_ExtensionMode;
    logic [2:0] o_word_size;

    control_unit_staged #(.DRAIN_CYCLES(DRAIN)) dut (
        .i_clk(clk), .i_reset(reset), .i_instruction(instr), .i_enable(enable), .i_flush(flush),
        .o_stall(o_stall), .o_ALUSrc(o_ALUSrc), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_reg_dir_to_write(o_reg_dir_to_write),
        .o_branch(o_branch), .o_jump(o_jump), .o_link(o_link), .o_halt(o_halt), .o_signed(o_signed),
        .o_ExtensionMode(o_ExtensionMode), .o_word_size(o_word_size), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       alu;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       rw;
        logic [4:0] dest;
        logic       br;
        logic       j;
        logic       link;
        logic       halt;
        logic       sgn;
        logic [1:0] ext;
        logic [2:0] ws;
    } cw_t;

    int   n_checks = 0;
    int   n_errors = 0;
    cw_t  m_cw;
    int   m_drain  = 0;
    bit   m_halted = 1'b0;
    bit   m_known  = 1'b0;
    int   halt_run = 0;

    logic [5:0] op_pool [20] = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03,
                                 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h28, 6'h29, 6'h2B, 6'h22};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cw_t bubble();
        cw_t c;
        c    = '0;
        c.ws = 3'd4;
        return c;
    endfunction

    // Opcode table: loads are 0x20-0x27 less 0x22/0x26, stores 0x28-0x2B less 0x2A;
    // low two bits give size, bit 2 of a load opcode marks the unsigned form.
    function automatic cw_t ref_decode(input logic [31:0] ins);
        cw_t        c;
        logic [5:0] op;
        logic [2:0] sz;
        c  = bubble();
        op = ins[31:26];
        sz = (op[1:0] == 2'd0) ? 3'd1 : ((op[1:0] == 2'd1) ? 3'd2 : 3'd4);
        if (ins == 32'hFFFF_FFFF) begin
            c.halt = 1'b1;
        end else if (op == 6'h00) begin
            c.rw   = 1'b1;
            c.dest = ins[15:11];
`ifdef CU_LINK_EN
            c.link = (ins[5:0] == 6'h09);
`endif
        end else if (op == 6'h08 || op == 6'h0A || (op >= 6'h0C && op <= 6'h0F)) begin
            c.alu  = 1'b1;
            c.rw   = 1'b1;
            c.dest = ins[20:16];
            c.ext  = (op >= 6'h0C) ? 2'd1 : 2'd0;
        end else if (op == 6'h04 || op == 6'h05) begin
            c.br = 1'b1;
        end else if (op == 6'h02) begin
            c.j = 1'b1;
`ifdef CU_LINK_EN
        end else if (op == 6'h03) begin
            c.j    = 1'b1;
            c.rw   = 1'b1;
            c.link = 1'b1;
            c.dest = 5'd31;
`endif
        end else if (op[5:3] == 3'b100 && op[1:0] != 2'b10) begin
            c.alu  = 1'b1;
            c.mr   = 1'b1;
            c.m2r  = 1'b1;
            c.rw   = 1'b1;
            c.dest = ins[20:16];
            c.sgn  = !op[2];
            c.ws   = sz;
        end else if (op[5:2] == 4'b1010 && op[1:0] != 2'b10) begin
            c.alu = 1'b1;
            c.mw  = 1'b1;
            c.ws  = sz;
        end
        return c;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ins);
        logic [5:0] op;
        bit         rt_read;
        op      = ins[31:26];
        rt_read = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
                  (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
        return m_cw.mr && (m_cw.dest != 5'd0) &&
               ((m_cw.dest == ins[25:21]) || (rt_read && (m_cw.dest == ins[20:16])));
    endfunction

    // One cycle: drive at the falling edge, check o_stall, advance model at the rising edge, check outputs.
    task automatic step(input string tag, input logic [31:0] ins, input logic en,
                        input logic fl, input logic rs);
        bit hz;
        @(negedge clk);
        instr  = ins;
        enable = en;
        flush  = fl;
        reset  = rs;
        #1;
        hz = !m_halted && (m_drain == 0) && !fl && ref_hazard(ins);
        if (m_known)
            check_eq({tag, "/stall"}, {31'd0, o_stall}, {31'd0, (hz || m_halted || (m_drain > 0))});
        @(posedge clk);
        if (rs) begin
            m_cw = bubble(); m_drain = 0; m_halted = 1'b0; m_known = 1'b1;
        end else if (!en) begin
            m_cw = m_cw;
        end else if (fl) begin
            m_cw = bubble(); m_drain = 0;
        end else if (m_halted) begin
            m_cw = bubble();
        end else if (m_drain > 0) begin
            m_cw = bubble(); m_drain--; m_halted = (m_drain == 0);
        end else if (hz) begin
            m_cw = bubble();
        end else begin
            m_cw = ref_decode(ins);
            if (m_cw.halt) m_drain = DRAIN;
        end
        #1;
        if (m_known)
            check_eq({tag, "/word"},
                     {11'd0, o_ALUSrc, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write,
                      o_reg_dir_to_write, o_branch, o_jump, o_link, o_halt, o_signed,
                      o_ExtensionMode, o_word_size, o_halted},
                     {11'd0, m_cw, m_halted});
    endtask

    localparam logic [31:0] ADDI = 32'h2005_0007;
    localparam logic [31:0] LW   = 32'h8C22_0000;
    localparam logic [31:0] ADD  = 32'h0044_1820;
    localparam logic [31:0] LW0  = 32'h8C20_0000;
    localparam logic [31:0] ADD0 = 32'h0004_1820;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] JAL  = 32'h0C00_0010;

    initial begin
        m_cw = bubble();
        step("reset", ADDI, 1'b1, 1'b0, 1'b1);
        step("reset", ADDI, 1'b1, 1'b0, 1'b1);
        step("addi", ADDI, 1'b1, 1'b0, 1'b0);
        check_eq("addi_dest", {27'd0, o_reg_dir_to_write}, 32'd5);
        check_eq("addi_alusrc", {31'd0, o_ALUSrc}, 32'd1);
        step("lw", LW, 1'b1, 1'b0, 1'b0);
        step("lu_stall", ADD, 1'b1, 1'b0, 1'b0);
        step("lu_add", ADD, 1'b1, 1'b0, 1'b0);
        check_eq("lu_add_dest", {27'd0, o_reg_dir_to_write}, 32'd3);
        step("lw0", LW0, 1'b1, 1'b0, 1'b0);
        step("lw0_add", ADD0, 1'b1, 1'b0, 1'b0);
        step("halt", HALT, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step("drain", NOP, 1'b1, 1'b0, 1'b0);
        check_eq("halted_held", {31'd0, o_halted}, 32'd1);
        step("flush_in_halted", NOP, 1'b1, 1'b1, 1'b0);
        // Drain stretched by i_enable gaps.
        step("rst2", NOP, 1'b1, 1'b0, 1'b1);
        step("halt2", HALT, 1'b1, 1'b0, 1'b0);
        step("drain_en", NOP, 1'b1, 1'b0, 1'b0);
        step("drain_hold", NOP, 1'b0, 1'b0, 1'b0);
        step("drain_hold", NOP, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("drain_en", NOP, 1'b1, 1'b0, 1'b0);
        // Flush against HALT, then flush one cycle into the drain.
        step("rst3", NOP, 1'b1, 1'b0, 1'b1);
        step("flush_halt", HALT, 1'b1, 1'b1, 1'b0);
        step("halt3", HALT, 1'b1, 1'b0, 1'b0);
        step("flush_drain", NOP, 1'b1, 1'b1, 1'b0);
        step("after_flush", ADDI, 1'b1, 1'b0, 1'b0);
        check_eq("no_halted", {31'd0, o_halted}, 32'd0);
        step("jal", JAL, 1'b1, 1'b0, 1'b0);
        step("branch", 32'h1022_0004, 1'b1, 1'b0, 1'b0);
        step("lbu", 32'h9023_0000, 1'b1, 1'b0, 1'b0);
        step("sh_rt_use", 32'hA403_0000, 1'b1, 1'b0, 1'b0);
        step("sh_after", 32'hA403_0000, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            logic        en;
            logic        fl;
            logic        rs;
            ins        = $urandom;
            ins[31:26] = op_pool[$urandom_range(0, 19)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            ins[15:11] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ins[5:0] = 6'h09;
            if ($urandom_range(0, 24) == 0) ins = HALT;
            en = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 99) == 0) || (halt_run > 5);
            step("rand", ins, en, fl, rs);
            halt_run = m_halted ? halt_run + 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
